unstriping_ctrl: RTL and testbench
==================================

UNSTRIPING_CTRL -- requirements
Module: unstriping_ctrl

Interface
REQ-001 Parameter CNT_W SHALL default to 16 and set the width of word_count.
REQ-002 clk_2f  input  1  SHALL be the single clock: the double-rate lane-merge clock; all state changes on its rising edge.
REQ-003 reset_L  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 enable  input  1  SHALL be the merge permission; 0 blocks new bursts and ends a running burst at the next pair boundary.
REQ-005 valid_in0  input  1  SHALL be the lane-0 word-valid flag.
REQ-006 valid_in1  input  1  SHALL be the lane-1 word-valid flag.
REQ-007 clear_err  input  1  SHALL be the synchronous clear for lane_err.
REQ-008 selector  output  1  SHALL be the registered mux select: 1 = lane 0 slot, 0 = lane 1 slot.
REQ-009 active  output  1  SHALL be high exactly while the FSM is in RUN.
REQ-010 burst_done  output  1  SHALL be a one-cycle pulse on every RUN->IDLE transition.
REQ-011 word_count  output  CNT_W  SHALL count valid words merged since reset.
REQ-012 lane_err  output  1  SHALL be a sticky lane-ordering error flag.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN, held in a registered state variable.
REQ-014 In IDLE, selector SHALL be 0.
REQ-015 IDLE->RUN SHALL occur at an edge sampling enable=1 and valid_in0=1; selector SHALL become 1 on that same edge.
REQ-016 In RUN, selector SHALL toggle on every edge, giving a lane-0 slot, then a lane-1 slot, and so on.
REQ-017 At an edge that ends a lane-0 slot (selector=1), the FSM SHALL stay in RUN and set selector to 0 unconditionally.
REQ-018 At an edge that ends a lane-1 slot (selector=0), the FSM SHALL stay in RUN with selector 1 if enable=1 and valid_in0=1.
REQ-019 Otherwise at that edge, the FSM SHALL go to IDLE with selector 0 and pulse burst_done.
REQ-020 Bursts SHALL therefore always end on a pair boundary; no burst SHALL end after a lane-0 slot.
REQ-021 Deasserting enable mid-burst SHALL complete the current lane-0/lane-1 pair before returning to IDLE.
REQ-022 A transition IDLE->RUN SHALL NOT occur in the same cycle as burst_done; re-entry needs at least one IDLE cycle.
REQ-023 word_count SHALL increment by 1 at each RUN edge whose current-slot valid is 1.
- Lane-0 slot: valid_in0.
- Lane-1 slot: valid_in1.
REQ-024 word_count SHALL saturate at all-ones and never wrap.
REQ-025 lane_err SHALL set at a lane-1-slot edge in RUN where valid_in1=1 and valid_in0=0 (lane 1 ahead of lane 0).
REQ-026 lane_err SHALL hold until clear_err=1; if set and clear coincide, set SHALL win.
REQ-027 The downstream mux adds one register stage, so merged data SHALL appear one clk_2f cycle after the corresponding selector value.

Reset
REQ-028 On reset_L=0, the block SHALL asynchronously force all of:
- state = IDLE
- selector = 0
- active = 0
- burst_done = 0
- word_count = 0
- lane_err = 0
REQ-029 Reset deassertion SHALL take effect at the next clk_2f edge.
REQ-030 Reset mid-burst SHALL abandon the burst without a burst_done pulse.

Structure
REQ-031 State encoding (IDLE=0, RUN=1) and the CNT_W default SHALL live in a shared package, unstriping_pkg.
REQ-032 The saturating counter SHALL be a sub-module, sat_counter (inputs: inc, clear; output: count), instantiated once.
REQ-033 All outputs SHALL be registered; there SHALL be no combinational input-to-output paths.

Verification
REQ-034 Burst of 3 pairs: release reset, enable=1, valid_in0/1=1 for 6 cycles, then 0.
- selector SHALL be 1,0,1,0,1,0.
- burst_done SHALL pulse once.
- word_count SHALL be 6.
REQ-035 Odd burst: valid_in0=1 for two lane-0 slots, valid_in1=1 only in the first lane-1 slot.
- word_count SHALL be 3.
- The FSM SHALL exit after the second lane-1 slot.
REQ-036 enable dropped during a lane-0 slot:
- The lane-1 slot SHALL still occur.
- IDLE SHALL follow on the next edge.
REQ-037 valid_in1=1 with valid_in0=0 at a lane-1 slot:
- lane_err SHALL go to 1.
- clear_err pulse SHALL clear it.
- Simultaneous set and clear SHALL leave it at 1.
REQ-038 reset_L=0 asserted mid-RUN, between edges:
- All outputs SHALL go to 0 immediately.
- No burst_done SHALL occur.
REQ-039 word_count preloaded near 0xFFFF (via forced stimulus) plus 4 valid words: count SHALL hold at 0xFFFF.

Source files
------------

// File: rtl/unstriping_pkg.sv
// Shared definitions for the lane-unstriping controller: FSM state encoding
// and the default width of the merged-word counter.
package unstriping_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping, with a synchronous
// clear and an asynchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  // Count up on inc, hold once every bit is set; clear has priority over inc.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/unstriping_ctrl.sv
// Lane-merge controller: alternates the downstream mux between lane 0 and
// lane 1 in pairs of slots, counts merged words and flags lane-ordering
// errors. A burst always ends after a lane-1 slot, never mid-pair.
module unstriping_ctrl
  import unstriping_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             valid_in0,
  input  logic             valid_in1,
  input  logic             clear_err,
  output logic             selector,
  output logic             active,
  output logic             burst_done,
  output logic [CNT_W-1:0] word_count,
  output logic             lane_err
);

  state_t state_reg;
  state_t state_next;
  logic   selector_next;
  logic   burst_done_next;
  logic   active_next;
  logic   lane_err_next;
  logic   lane0_slot;
  logic   lane1_slot;
  logic   err_set;
  logic   word_inc;

  // While running, selector=1 marks the lane-0 slot and selector=0 the lane-1 slot.
  assign lane0_slot = (state_reg == RUN) && selector;
  assign lane1_slot = (state_reg == RUN) && !selector;

  // A word is merged whenever the lane owning the current slot presents valid data.
  assign word_inc = (lane0_slot && valid_in0) || (lane1_slot && valid_in1);

  // Lane 1 delivering while lane 0 has nothing means the lanes have slipped.
  assign err_set = lane1_slot && valid_in1 && !valid_in0;

  // Next-state and next-output decode; exits are only decided at the end of a lane-1 slot.
  always_comb begin
    state_next      = state_reg;
    selector_next   = 1'b0;
    burst_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && valid_in0) begin
          state_next    = RUN;
          selector_next = 1'b1;
        end
      end
      RUN: begin
        if (selector) begin
          // Lane-0 slot always hands over to its lane-1 partner.
          state_next    = RUN;
          selector_next = 1'b0;
        end else if (enable && valid_in0) begin
          // Pair complete and another lane-0 word is ready: keep going.
          state_next    = RUN;
          selector_next = 1'b1;
        end else begin
          state_next      = IDLE;
          burst_done_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    active_next   = (state_next == RUN);
    lane_err_next = err_set || (lane_err && !clear_err);
  end

  // Register the FSM state and every control output so nothing is combinational from inputs.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_reg  <= IDLE;
      selector   <= 1'b0;
      active     <= 1'b0;
      burst_done <= 1'b0;
      lane_err   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      selector   <= selector_next;
      active     <= active_next;
      burst_done <= burst_done_next;
      lane_err   <= lane_err_next;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_word_counter (
    .clk     (clk_2f),
    .reset_L (reset_L),
    .inc     (word_inc),
    .clear   (1'b0),
    .count   (word_count)
  );

endmodule

// File: tb/tb_unstriping_ctrl.sv
// Self-checking bench for unstriping_ctrl. A slot-level model predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
// A second 4-bit-counter instance shares the stimulus so saturation is
// reached in a few dozen words.
module tb_unstriping_ctrl;

  logic        clk_2f    = 1'b0;
  logic        reset_L   = 1'b0;
  logic        enable    = 1'b0;
  logic        valid_in0 = 1'b0;
  logic        valid_in1 = 1'b0;
  logic        clear_err = 1'b0;

  logic        selector, active, burst_done, lane_err;
  logic [15:0] word_count;
  logic        selector_n, active_n, burst_done_n, lane_err_n;
  logic [3:0]  word_count_n;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on   = 1'b0;

  unstriping_ctrl dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .enable     (enable),
    .valid_in0  (valid_in0),
    .valid_in1  (valid_in1),
    .clear_err  (clear_err),
    .selector   (selector),
    .active     (active),
    .burst_done (burst_done),
    .word_count (word_count),
    .lane_err   (lane_err)
  );

  unstriping_ctrl #(.CNT_W(4)) dut_narrow (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .enable     (enable),
    .valid_in0  (valid_in0),
    .valid_in1  (valid_in1),
    .clear_err  (clear_err),
    .selector   (selector_n),
    .active     (active_n),
    .burst_done (burst_done_n),
    .word_count (word_count_n),
    .lane_err   (lane_err_n)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_slot = number of slots already finished in the current burst; even = lane-0 slot.
  // m_words = total merged words since reset (unbounded; saturation applied on compare).
  bit m_busy;
  int m_slot;
  bit m_done;
  bit m_err;
  int m_words;

  function automatic int clamp(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(posedge clk_2f or negedge reset_L) begin : model
    bit lane0;
    bit set_e;
    if (!reset_L) begin
      m_busy  = 1'b0;
      m_slot  = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_words = 0;
    end else begin
      m_done = 1'b0;
      lane0  = m_busy && ((m_slot % 2) == 0);
      set_e  = m_busy && !lane0 && valid_in1 && !valid_in0;
      if (m_busy && (lane0 ? valid_in0 : valid_in1)) m_words++;
      if (set_e) m_err = 1'b1;
      else if (clear_err) m_err = 1'b0;
      if (!m_busy) begin
        if (enable && valid_in0) begin
          m_busy = 1'b1;
          m_slot = 0;
        end
      end else if (lane0 || (enable && valid_in0)) begin
        m_slot++;
      end else begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model, away from the active edge.
  always @(negedge clk_2f) begin
    if (cmp_on) begin
      chk("cyc_selector",   32'(selector),     32'(m_busy && ((m_slot % 2) == 0)));
      chk("cyc_active",     32'(active),       32'(m_busy));
      chk("cyc_burst_done", 32'(burst_done),   32'(m_done));
      chk("cyc_lane_err",   32'(lane_err),     32'(m_err));
      chk("cyc_word_count", 32'(word_count),   32'(clamp(m_words, 65535)));
      chk("cyc_count_w4",   32'(word_count_n), 32'(clamp(m_words, 15)));
    end
  end

  // Apply one input vector (at a negedge) and return at the next negedge, after the edge it drives.
  task automatic cyc(input bit en, input bit v0, input bit v1, input bit clr);
    enable    = en;
    valid_in0 = v0;
    valid_in1 = v1;
    clear_err = clr;
    @(negedge clk_2f);
  endtask

  // Burst of n full pairs, every word valid; enable dropped during the last lane-1 slot.
  task automatic run_pairs(input int n);
    cyc(1, 1, 1, 0);
    for (int p = 0; p < n; p++) begin
      cyc(1, 1, 1, 0);
      cyc((p == n - 1) ? 1'b0 : 1'b1, 1, 1, 0);
    end
    cyc(0, 0, 0, 0);
  endtask

  logic [5:0] sel_seq;

  initial begin
    // Reset held over two edges, then reset values checked.
    repeat (2) @(posedge clk_2f);
    @(negedge clk_2f);
    chk("rst_selector",   32'(selector),   32'd0);
    chk("rst_active",     32'(active),     32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_lane_err",   32'(lane_err),   32'd0);
    reset_L = 1'b1;
    cmp_on  = 1'b1;
    cyc(0, 0, 0, 0);

    // Three full pairs: 6 slots with selector 1,0,1,0,1,0 and 6 words.
    cyc(1, 1, 1, 0);
    sel_seq[5] = selector;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, 0);
      sel_seq[4 - i] = selector;
    end
    chk("t1_sel_sequence", 32'(sel_seq), 32'h2A);
    chk("t1_no_early_done", 32'(burst_done), 32'd0);
    cyc(0, 1, 1, 0);
    chk("t1_done_pulse", 32'(burst_done), 32'd1);
    chk("t1_idle",       32'(active),     32'd0);
    chk("t1_count",      32'(word_count), 32'd6);
    chk("t1_no_err",     32'(lane_err),   32'd0);
    cyc(0, 0, 0, 0);
    chk("t1_done_single", 32'(burst_done), 32'd0);

    // Odd burst: lane 0 valid twice, lane 1 only in the first lane-1 slot.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    chk("t2_still_run", 32'(active), 32'd1);
    cyc(1, 0, 0, 0);
    chk("t2_exit_done", 32'(burst_done), 32'd1);
    chk("t2_count",     32'(word_count), 32'd9);
    cyc(0, 0, 0, 0);

    // Enable dropped during the lane-0 slot: lane-1 slot still happens.
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    chk("t3_lane1_slot_active", 32'(active),   32'd1);
    chk("t3_lane1_slot_sel",    32'(selector), 32'd0);
    cyc(0, 1, 1, 0);
    chk("t3_idle_done", 32'(burst_done), 32'd1);
    chk("t3_idle",      32'(active),     32'd0);
    chk("t3_count",     32'(word_count), 32'd11);
    cyc(0, 0, 0, 0);

    // Lane 1 ahead of lane 0: error set, cleared, then set+clear together keeps it.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 0);
    chk("t4_err_set",   32'(lane_err),   32'd1);
    chk("t4_count",     32'(word_count), 32'd13);
    cyc(0, 0, 0, 1);
    chk("t4_err_clear", 32'(lane_err), 32'd0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 1);
    chk("t4_set_wins", 32'(lane_err), 32'd1);
    cyc(0, 0, 0, 1);
    chk("t4_err_clear2", 32'(lane_err), 32'd0);
    cyc(0, 0, 0, 0);

    // Reset asserted between edges in the middle of a burst.
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    #2;
    reset_L = 1'b0;
    #1;
    chk("t5_async_selector",   32'(selector),   32'd0);
    chk("t5_async_active",     32'(active),     32'd0);
    chk("t5_async_burst_done", 32'(burst_done), 32'd0);
    chk("t5_async_word_count", 32'(word_count), 32'd0);
    chk("t5_async_lane_err",   32'(lane_err),   32'd0);
    @(negedge clk_2f);
    cyc(1, 1, 1, 0);
    reset_L = 1'b1;
    cyc(0, 0, 0, 0);
    chk("t5_no_done_after", 32'(burst_done), 32'd0);
    chk("t5_idle_after",    32'(active),     32'd0);

    // Saturation, using the 4-bit instance: bring it near its ceiling, then add 4 more words.
    run_pairs(6);
    chk("t6_near_max_w4", 32'(word_count_n), 32'd12);
    chk("t6_count_w16",   32'(word_count),   32'd12);
    run_pairs(2);
    chk("t6_saturated_w4", 32'(word_count_n), 32'd15);
    chk("t6_count_w16b",   32'(word_count),   32'd16);
    run_pairs(1);
    chk("t6_holds_w4", 32'(word_count_n), 32'd15);

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
